// File: rtl/cafetera_dispense_ctrl.sv
// -----------------------------------------------------------------------------
// cafetera_dispense_ctrl
//   Sequences the brewing actuators and change-return coin ejector for one
//   accepted sale: GRIND -> WATER -> [MILK -> [CHOC]] -> CHANGE -> DONE.
//   A customer abort during brewing stops the actuators and refunds the
//   change owed plus the drink price, one coin at a time.
//
// Optional feature: define CAFETERA_STATS_EN to build the saturating
//   cups_served counter. When it is undefined, cups_served is tied to 0.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   order_valid     order request, accepted in IDLE only
//   order_sel[1:0]  drink: 0 expreso, 1 con leche, 2 capuccino, 3 mocaccino
//   change_amt[3:0] change owed, in 100-colon coins
//   abort           customer cancel, honoured during brewing stages only
//   order_ready     high only in IDLE
//   grind_on, water_on, milk_on, foam_on, choc_on   actuator enables
//   coin_out        one-cycle pulse per ejected coin
//   done            one-cycle completion pulse
//   refunded        qualifies done: the order was aborted
//   cups_served     completed (non-aborted) order count
// -----------------------------------------------------------------------------
module cafetera_dispense_ctrl #(
    parameter int GRIND_CYC = 4,
    parameter int WATER_CYC = 6,
    parameter int MILK_CYC  = 3,
    parameter int CHOC_CYC  = 2,
    parameter int COIN_GAP  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        order_valid,
    input  logic [1:0]  order_sel,
    input  logic [3:0]  change_amt,
    input  logic        abort,
    output logic        order_ready,
    output logic        grind_on,
    output logic        water_on,
    output logic        milk_on,
    output logic        foam_on,
    output logic        choc_on,
    output logic        coin_out,
    output logic        done,
    output logic        refunded,
    output logic [15:0] cups_served
);

    typedef enum logic [2:0] {
        S_IDLE, S_GRIND, S_WATER, S_MILK, S_CHOC, S_CHANGE, S_DONE
    } state_t;

    localparam int CW = 8;
    localparam logic [CW-1:0] GRIND_LAST = CW'(GRIND_CYC - 1);
    localparam logic [CW-1:0] WATER_LAST = CW'(WATER_CYC - 1);
    localparam logic [CW-1:0] MILK_LAST  = CW'(MILK_CYC - 1);
    localparam logic [CW-1:0] CHOC_LAST  = CW'(CHOC_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(COIN_GAP);

    state_t        state, nstate, stage_next, brew_end;
    logic [CW-1:0] cnt, ncnt, stage_last;
    logic [1:0]    sel, nsel;
    logic [4:0]    coins, ncoins;   // change owed, later the refund (max 15+7)
    logic          aborted, naborted;

    function automatic logic [4:0] price(input logic [1:0] s);
        case (s)
            2'd0:    price = 5'd3;
            2'd1:    price = 5'd4;
            2'd2:    price = 5'd5;
            default: price = 5'd7;
        endcase
    endfunction

    // Where the recipe ends: with nothing owed the CHANGE stage is skipped.
    assign brew_end = (coins == 5'd0) ? S_DONE : S_CHANGE;

    always_comb begin
        stage_last = GRIND_LAST;
        stage_next = S_WATER;
        case (state)
            S_WATER: begin
                stage_last = WATER_LAST;
                stage_next = (sel == 2'd0) ? brew_end : S_MILK;
            end
            S_MILK: begin
                stage_last = MILK_LAST;
                stage_next = (sel == 2'd3) ? S_CHOC : brew_end;
            end
            S_CHOC: begin
                stage_last = CHOC_LAST;
                stage_next = brew_end;
            end
            default: ;
        endcase
    end

    always_comb begin
        nstate   = state;
        ncnt     = cnt + CW'(1);
        nsel     = sel;
        ncoins   = coins;
        naborted = aborted;
        case (state)
            S_IDLE: begin
                ncnt = '0;
                if (order_valid) begin
                    nstate   = S_GRIND;
                    nsel     = order_sel;
                    ncoins   = {1'b0, change_amt};
                    naborted = 1'b0;
                end
            end
            S_GRIND, S_WATER, S_MILK, S_CHOC: begin
                // Abort wins over an end-of-stage transition in the same cycle.
                if (abort) begin
                    nstate   = S_CHANGE;
                    ncnt     = '0;
                    ncoins   = coins + price(sel);
                    naborted = 1'b1;
                end else if (cnt == stage_last) begin
                    nstate = stage_next;
                    ncnt   = '0;
                end
            end
            S_CHANGE: begin
                // cnt==0 is the pulse cycle; then COIN_GAP idle cycles.
                if (cnt == '0) begin
                    ncoins = coins - 5'd1;
                    if (coins == 5'd1) begin
                        nstate = S_DONE;
                        ncnt   = '0;
                    end
                end else if (cnt == GAP_LAST) begin
                    ncnt = '0;
                end
            end
            S_DONE: begin
                nstate = S_IDLE;
                ncnt   = '0;
            end
            default: begin
                nstate = S_IDLE;
                ncnt   = '0;
            end
        endcase
    end

    // Outputs are registered, decoded from the next state so they line up
    // with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            sel         <= '0;
            coins       <= '0;
            aborted     <= 1'b0;
            order_ready <= 1'b1;
            grind_on    <= 1'b0;
            water_on    <= 1'b0;
            milk_on     <= 1'b0;
            foam_on     <= 1'b0;
            choc_on     <= 1'b0;
            coin_out    <= 1'b0;
            done        <= 1'b0;
            refunded    <= 1'b0;
        end else begin
            state       <= nstate;
            cnt         <= ncnt;
            sel         <= nsel;
            coins       <= ncoins;
            aborted     <= naborted;
            order_ready <= (nstate == S_IDLE);
            grind_on    <= (nstate == S_GRIND);
            water_on    <= (nstate == S_WATER);
            milk_on     <= (nstate == S_MILK) && nsel[0];      // drinks 1, 3
            foam_on     <= (nstate == S_MILK) && (nsel == 2'd2);
            choc_on     <= (nstate == S_CHOC);
            coin_out    <= (nstate == S_CHANGE) && (ncnt == '0);
            done        <= (nstate == S_DONE);
            refunded    <= (nstate == S_DONE) && naborted;
        end
    end

`ifdef CAFETERA_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cups_served <= '0;
        else if (state == S_DONE && !aborted && cups_served != 16'hFFFF)
            cups_served <= cups_served + 16'd1;
    end
`else
    assign cups_served = '0;
`endif

endmodule

// File: tb/tb_cafetera_dispense_ctrl.sv
module tb_cafetera_dispense_ctrl;

    localparam int COIN_GAP = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        order_valid, abort;
    logic [1:0]  order_sel;
    logic [3:0]  change_amt;
    logic        order_ready, grind_on, water_on, milk_on, foam_on, choc_on;
    logic        coin_out, done, refunded;
    logic [15:0] cups_served;

    int applied = 0;
    int errs    = 0;

    cafetera_dispense_ctrl #(
        .GRIND_CYC(4), .WATER_CYC(6), .MILK_CYC(3), .CHOC_CYC(2), .COIN_GAP(COIN_GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .order_valid(order_valid), .order_sel(order_sel),
        .change_amt(change_amt), .abort(abort), .order_ready(order_ready),
        .grind_on(grind_on), .water_on(water_on), .milk_on(milk_on), .foam_on(foam_on),
        .choc_on(choc_on), .coin_out(coin_out), .done(done), .refunded(refunded),
        .cups_served(cups_served)
    );

    always #5 clk = ~clk;

    // One order per record. Cycle 0 is the cycle whose closing edge accepts it.
    // ab/ov1/ov2: cycle in which abort / an extra order_valid pulse is driven (-1 none).
    // Expected: first cycle and length of grind/water, milk/foam/choc lengths,
    // coin count and first coin cycle, done cycle, refunded.
    typedef struct {
        int sel, chg, ab, ov1, ov2;
        int g1, gn, w1, wn, mn, fn, cn, kn, k1, dc, rf;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        applied++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_row(input int idx, input vec_t v);
        int g1 = -1, gn = 0, w1 = -1, wn = 0, mn = 0, fn = 0, cn = 0;
        int kn = 0, k1 = -1, last_k = -1, gaperr = 0, multi = 0;
        int dc = -1, rf = -1, dn = 0, rdy = -1;
        for (int c = 0; c < 200; c++) begin
            order_valid = (c == 0) || (c == v.ov1) || (c == v.ov2);
            order_sel   = 2'(v.sel);
            change_amt  = 4'(v.chg);
            abort       = (c == v.ab);
            @(negedge clk);
            if (grind_on) begin gn++; if (g1 < 0) g1 = c; end
            if (water_on) begin wn++; if (w1 < 0) w1 = c; end
            if (milk_on) mn++;
            if (foam_on) fn++;
            if (choc_on) cn++;
            if (coin_out) begin
                kn++;
                if (k1 < 0) k1 = c;
                if (last_k >= 0 && c - last_k != COIN_GAP + 1) gaperr++;
                last_k = c;
            end
            if (int'(grind_on) + int'(water_on) + int'(milk_on) + int'(foam_on) + int'(choc_on) > 1)
                multi++;
            if (done) begin
                dn++;
                if (dc < 0) begin dc = c; rf = int'(refunded); end
            end
            if (dc >= 0 && c == dc + 1) rdy = int'(order_ready);
            @(posedge clk); #1;
            if (dc >= 0 && c >= dc + 4) break;
        end
        order_valid = 1'b0;
        abort       = 1'b0;
        chk($sformatf("row%0d grind_first", idx), g1, v.g1);
        chk($sformatf("row%0d grind_cycles", idx), gn, v.gn);
        chk($sformatf("row%0d water_first", idx), w1, v.w1);
        chk($sformatf("row%0d water_cycles", idx), wn, v.wn);
        chk($sformatf("row%0d milk_cycles", idx), mn, v.mn);
        chk($sformatf("row%0d foam_cycles", idx), fn, v.fn);
        chk($sformatf("row%0d choc_cycles", idx), cn, v.cn);
        chk($sformatf("row%0d coins", idx), kn, v.kn);
        chk($sformatf("row%0d first_coin", idx), k1, v.k1);
        chk($sformatf("row%0d coin_gap_errors", idx), gaperr, 0);
        chk($sformatf("row%0d done_cycle", idx), dc, v.dc);
        chk($sformatf("row%0d refunded", idx), rf, v.rf);
        chk($sformatf("row%0d ready_after_done", idx), rdy, 1);
        chk($sformatf("row%0d multi_actuator", idx), multi, 0);
        chk($sformatf("row%0d done_pulses", idx), dn, 1);
    endtask

    function automatic int outs();
        return {order_ready, grind_on, water_on, milk_on, foam_on, choc_on,
                coin_out, done, refunded};
    endfunction

    initial begin
        int stray;
        int exp_cups;
        //          sel chg  ab ov1 ov2   g1 gn  w1 wn mn fn cn  kn  k1  dc rf
        vecs[0] = '{0,  0,  -1, -1, -1,   1, 4,  5, 6, 0, 0, 0,  0, -1, 11, 0};
        vecs[1] = '{1,  3,  -1, -1, -1,   1, 4,  5, 6, 3, 0, 0,  3, 14, 21, 0};
        vecs[2] = '{2,  0,  -1, -1, -1,   1, 4,  5, 6, 0, 3, 0,  0, -1, 14, 0};
        vecs[3] = '{3,  2,  -1, -1, -1,   1, 4,  5, 6, 3, 0, 2,  2, 16, 20, 0};
        vecs[4] = '{2,  1,   7, -1, -1,   1, 4,  5, 3, 0, 0, 0,  6,  8, 24, 1};
        vecs[5] = '{0, 15,   1, -1, -1,   1, 1, -1, 0, 0, 0, 0, 18,  2, 54, 1};
        vecs[6] = '{3, 15,  15, -1, -1,   1, 4,  5, 6, 3, 0, 2, 22, 16, 80, 1};
        vecs[7] = '{1,  0,   4, -1, -1,   1, 4, -1, 0, 0, 0, 0,  4,  5, 15, 1};
        vecs[8] = '{1,  1,  14,  3, 12,   1, 4,  5, 6, 3, 0, 0,  1, 14, 15, 0};
        vecs[9] = '{0,  1,   0, -1, -1,   1, 4,  5, 6, 0, 0, 0,  1, 11, 12, 0};

        rst_n = 1'b0; order_valid = 1'b0; abort = 1'b0; order_sel = '0; change_amt = '0;
        @(negedge clk);
        chk("reset outputs", outs(), 9'b1_0000_0000);
        chk("reset cups_served", int'(cups_served), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset in the middle of GRIND drops the actuator without a clock edge.
        @(posedge clk); #1;
        order_valid = 1'b1; order_sel = 2'd3; change_amt = 4'd5;
        @(posedge clk); #1;
        order_valid = 1'b0;
        @(posedge clk); #1;
        chk("grind before reset", int'(grind_on), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset outputs", outs(), 9'b1_0000_0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (outs() != 9'b1_0000_0000) stray++;
        end
        chk("idle after reset release", stray, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) run_row(i, vecs[i]);

`ifdef CAFETERA_STATS_EN
        exp_cups = 6;
`else
        exp_cups = 0;
`endif
        @(negedge clk);
        chk("cups_served", int'(cups_served), exp_cups);

        $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
        $finish;
    end

endmodule
